// File: rtl/alu_seq_if.sv
// Request and register-file bus bundle for the alu_seq sequencer.
// master: the sequencer side; slave: requester plus register file side.
interface alu_seq_if #(parameter int W = 8);
  logic         start;
  logic [3:0]   op;
  logic [1:0]   dst;
  logic [1:0]   src;
  logic [W-1:0] p;
  logic [W-1:0] fod;
  logic [W-1:0] d;
  logic         as, bs, cs, ds, fs;
  logic         re, we;
  logic         busy;
  logic         done;

  modport master (
    input  start, op, dst, src, p, fod,
    output d, as, bs, cs, ds, fs, re, we, busy, done
  );

  modport slave (
    output start, op, dst, src, p, fod,
    input  d, as, bs, cs, ds, fs, re, we, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU sequencer mastering the 8-bit register file (a,b,c,d,f).
// Define ALU_CARRY_IN_EN to enable ADC/SBC (opcodes 8/9); otherwise they run as NOP.
module alu_seq (
  input  logic        clk,
  input  logic        rst,
  alu_seq_if.master   bus
);
  localparam int W = 8;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_INC = 4'd5;
  localparam logic [3:0] OP_DEC = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_SBC = 4'd9;

  typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WRR, WRF, NOP} state_t;

  state_t       state, nxt;
  logic [3:0]   op_q;
  logic [1:0]   dst_q, src_q;
  logic [W-1:0] a_q, b_q, r_q, f_q;
  logic [W-1:0] r_n, f_n;
  logic         done_q;
  logic         reserved;
  logic         accept;
  logic [3:0]   sel_dst, sel_src;

  logic unused_fod;
  assign unused_fod = ^{bus.fod[7:4], bus.fod[2:1]};

`ifdef ALU_CARRY_IN_EN
  assign reserved = (bus.op > OP_SBC);
`else
  assign reserved = (bus.op > OP_MOV);
`endif

  assign accept  = (state == IDLE) && bus.start;
  assign sel_dst = 4'b0001 << dst_q;
  assign sel_src = 4'b0001 << src_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      done_q <= (state == WRF) || (state == NOP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      dst_q <= '0;
      src_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      f_q   <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.op;
        dst_q <= bus.dst;
        src_q <= bus.src;
      end
      if (state == RDA)  a_q <= bus.p;
      if (state == RDB)  b_q <= bus.p;
      if (state == EXEC) begin
        r_q <= r_n;
        f_q <= f_n;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (bus.start) begin
        if (reserved)             nxt = NOP;
        else if (bus.op == OP_MOV) nxt = RDB;
        else                       nxt = RDA;
      end
      RDA:     nxt = (op_q == OP_INC || op_q == OP_DEC) ? EXEC : RDB;
      RDB:     nxt = EXEC;
      EXEC:    nxt = WRR;
      WRR:     nxt = WRF;
      WRF:     nxt = IDLE;
      NOP:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.d    = '0;
    bus.as   = 1'b0;
    bus.bs   = 1'b0;
    bus.cs   = 1'b0;
    bus.ds   = 1'b0;
    bus.fs   = 1'b0;
    bus.re   = 1'b0;
    bus.we   = 1'b0;
    bus.busy = (state != IDLE);
    bus.done = done_q;
    case (state)
      RDA: begin
        bus.re = 1'b1;
        {bus.ds, bus.cs, bus.bs, bus.as} = sel_dst;
      end
      RDB: begin
        bus.re = 1'b1;
        {bus.ds, bus.cs, bus.bs, bus.as} = sel_src;
      end
      WRR: begin
        bus.we = 1'b1;
        bus.d  = r_q;
        {bus.ds, bus.cs, bus.bs, bus.as} = sel_dst;
      end
      WRF: begin
        bus.we = 1'b1;
        bus.fs = 1'b1;
        bus.d  = f_q;
      end
      default: ;
    endcase
  end

  // 9-bit datapath: bit 8 is carry for additions and borrow for subtractions.
  always_comb begin
    logic [W:0] sum;
    logic       c, v;
    sum = '0;
    r_n = a_q;
    c   = bus.fod[0];
    v   = bus.fod[3];
    case (op_q)
      OP_ADD: begin
        sum = {1'b0, a_q} + {1'b0, b_q};
        r_n = sum[W-1:0];
        c   = sum[W];
        v   = (a_q[W-1] == b_q[W-1]) && (r_n[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        sum = {1'b0, a_q} - {1'b0, b_q};
        r_n = sum[W-1:0];
        c   = sum[W];
        v   = (a_q[W-1] != b_q[W-1]) && (r_n[W-1] != a_q[W-1]);
      end
      OP_AND: begin r_n = a_q & b_q; c = 1'b0; v = 1'b0; end
      OP_OR:  begin r_n = a_q | b_q; c = 1'b0; v = 1'b0; end
      OP_XOR: begin r_n = a_q ^ b_q; c = 1'b0; v = 1'b0; end
      OP_INC: begin
        sum = {1'b0, a_q} + 9'd1;
        r_n = sum[W-1:0];
        v   = !a_q[W-1] && r_n[W-1];
      end
      OP_DEC: begin
        sum = {1'b0, a_q} - 9'd1;
        r_n = sum[W-1:0];
        v   = a_q[W-1] && !r_n[W-1];
      end
      OP_MOV: r_n = b_q;
`ifdef ALU_CARRY_IN_EN
      OP_ADC: begin
        sum = {1'b0, a_q} + {1'b0, b_q} + {8'b0, bus.fod[0]};
        r_n = sum[W-1:0];
        c   = sum[W];
        v   = (a_q[W-1] == b_q[W-1]) && (r_n[W-1] != a_q[W-1]);
      end
      OP_SBC: begin
        sum = {1'b0, a_q} - {1'b0, b_q} - {8'b0, bus.fod[0]};
        r_n = sum[W-1:0];
        c   = sum[W];
        v   = (a_q[W-1] != b_q[W-1]) && (r_n[W-1] != a_q[W-1]);
      end
`endif
      default: ;
    endcase
    f_n = {4'b0000, v, r_n[W-1], (r_n == '0), c};
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with a behavioural register file.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if bus ();
  alu_seq dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [7:0] rf [0:4];
  logic       pre_en = 1'b0;
  int         pre_idx = 0;
  logic [7:0] pre_val = '0;
  int         sel_idx;
  int         wr_cnt = 0;
  int         done_cnt = 0;
  int         rdb_cnt = 0;
  int         viol = 0;

  always_comb begin
    sel_idx = 0;
    if (bus.bs) sel_idx = 1;
    if (bus.cs) sel_idx = 2;
    if (bus.ds) sel_idx = 3;
    if (bus.fs) sel_idx = 4;
  end

  assign bus.p   = bus.re ? rf[sel_idx] : 8'hA5;
  assign bus.fod = rf[4];

  always @(posedge clk) begin
    if (pre_en) rf[pre_idx] <= pre_val;
    else if (bus.we) begin
      rf[sel_idx] <= bus.d;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  always @(negedge clk) begin
    if ($countones({bus.as, bus.bs, bus.cs, bus.ds, bus.fs}) > 1) viol <= viol + 1;
    else if (bus.re && bus.we) viol <= viol + 1;
    else if (bus.fs && bus.re) viol <= viol + 1;
    if (bus.re && bus.bs) rdb_cnt <= rdb_cnt + 1;
  end

  task automatic poke(input int idx, input logic [7:0] v);
    pre_idx = idx;
    pre_val = v;
    pre_en  = 1'b1;
    @(posedge clk); #1;
    pre_en  = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [1:0] dd, input logic [1:0] ss,
                        output int n);
    bus.start = 1'b1;
    bus.op = o; bus.dst = dd; bus.src = ss;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!bus.done) begin
      $display("FAIL op%0d completion: no done within %0d cycles", o, n);
      errors++;
      n = -1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) poke(i, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.d !== 8'h00) begin $display("FAIL reset d: got %h want 00", bus.d); errors++; end
    checks++;
    if ({bus.as, bus.bs, bus.cs, bus.ds, bus.fs} !== 5'b0) begin
      $display("FAIL reset selects: got %b want 00000", {bus.as, bus.bs, bus.cs, bus.ds, bus.fs}); errors++;
    end
    checks++;
    if ({bus.re, bus.we} !== 2'b00) begin $display("FAIL reset strobes: got %b want 00", {bus.re, bus.we}); errors++; end
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin $display("FAIL reset busy/done: got %b want 00", {bus.busy, bus.done}); errors++; end
  endtask

  task automatic test_add();
    int n;
    poke(0, 8'h7F); poke(1, 8'h01); poke(4, 8'h00);
    run_op(4'd0, 2'd0, 2'd1, n);
    checks++;
    if (n !== 6) begin $display("FAIL add latency: got %0d want 6", n); errors++; end
    checks++;
    if (rf[0] !== 8'h80) begin $display("FAIL add result: got %h want 80", rf[0]); errors++; end
    checks++;
    if (rf[4] !== 8'h0C) begin $display("FAIL add flags: got %h want 0c", rf[4]); errors++; end
    checks++;
    if (rf[1] !== 8'h01) begin $display("FAIL add src kept: got %h want 01", rf[1]); errors++; end
  endtask

  task automatic test_sub_dec();
    int n;
    poke(2, 8'h00); poke(3, 8'h01);
    run_op(4'd1, 2'd2, 2'd3, n);
    checks++;
    if (rf[2] !== 8'hFF) begin $display("FAIL sub result: got %h want ff", rf[2]); errors++; end
    checks++;
    if (rf[4] !== 8'h05) begin $display("FAIL sub flags: got %h want 05", rf[4]); errors++; end
    run_op(4'd6, 2'd2, 2'd0, n);
    checks++;
    if (n !== 5) begin $display("FAIL dec latency: got %0d want 5", n); errors++; end
    checks++;
    if (rf[2] !== 8'hFE) begin $display("FAIL dec result: got %h want fe", rf[2]); errors++; end
    checks++;
    if (rf[4] !== 8'h05) begin $display("FAIL dec flags: got %h want 05", rf[4]); errors++; end
  endtask

  task automatic test_mov();
    int n, rb;
    poke(1, 8'h55); poke(3, 8'h00); poke(4, 8'h09);
    rb = rdb_cnt;
    run_op(4'd7, 2'd1, 2'd3, n);
    checks++;
    if (n !== 5) begin $display("FAIL mov latency: got %0d want 5", n); errors++; end
    checks++;
    if (rf[1] !== 8'h00) begin $display("FAIL mov result: got %h want 00", rf[1]); errors++; end
    checks++;
    if (rf[4] !== 8'h0B) begin $display("FAIL mov flags: got %h want 0b", rf[4]); errors++; end
    checks++;
    if (rdb_cnt !== rb) begin $display("FAIL mov read of b: got %0d reads want 0", rdb_cnt - rb); errors++; end
  endtask

  task automatic test_xor();
    int n;
    poke(0, 8'hF0); poke(2, 8'h3C); poke(4, 8'h0F);
    run_op(4'd4, 2'd0, 2'd2, n);
    checks++;
    if (rf[0] !== 8'hCC) begin $display("FAIL xor result: got %h want cc", rf[0]); errors++; end
    checks++;
    if (rf[4] !== 8'h04) begin $display("FAIL xor flags: got %h want 04", rf[4]); errors++; end
  endtask

  task automatic test_reset_midop();
    int n, wc, dc;
    poke(0, 8'h10); poke(1, 8'h20); poke(4, 8'h00);
    wc = wr_cnt; dc = done_cnt;
    bus.start = 1'b1; bus.op = 4'd0; bus.dst = 2'd0; bus.src = 2'd1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.re, bus.we} !== 3'b100) begin
      $display("FAIL exec cycle: got busy/re/we %b want 100", {bus.busy, bus.re, bus.we}); errors++;
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin $display("FAIL midop reset busy: got %b want 0", bus.busy); errors++; end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt !== wc) begin $display("FAIL midop writes: got %0d want 0", wr_cnt - wc); errors++; end
    checks++;
    if (done_cnt !== dc) begin $display("FAIL midop done: got %0d pulses want 0", done_cnt - dc); errors++; end
    checks++;
    if (rf[0] !== 8'h10) begin $display("FAIL midop dst kept: got %h want 10", rf[0]); errors++; end
    run_op(4'd0, 2'd0, 2'd1, n);
    checks++;
    if (n !== 6) begin $display("FAIL post-reset latency: got %0d want 6", n); errors++; end
    checks++;
    if ({rf[0], rf[4]} !== 16'h3000) begin $display("FAIL post-reset add: got %h want 3000", {rf[0], rf[4]}); errors++; end
  endtask

  task automatic test_back_to_back();
    int n;
    poke(1, 8'h30); poke(3, 8'h03); poke(4, 8'h08);
    run_op(4'd3, 2'd1, 2'd3, n);
    checks++;
    if ({rf[1], rf[4]} !== 16'h3300) begin $display("FAIL or result/flags: got %h want 3300", {rf[1], rf[4]}); errors++; end
    checks++;
    if (bus.busy !== 1'b0) begin $display("FAIL done-cycle busy: got %b want 0", bus.busy); errors++; end
    run_op(4'd5, 2'd3, 2'd0, n);
    checks++;
    if (n !== 5) begin $display("FAIL b2b inc latency: got %0d want 5", n); errors++; end
    checks++;
    if ({rf[3], rf[4]} !== 16'h0400) begin $display("FAIL b2b inc result/flags: got %h want 0400", {rf[3], rf[4]}); errors++; end
  endtask

  task automatic test_carry_in();
    int n, wc;
    poke(0, 8'hFF); poke(1, 8'h00); poke(4, 8'h01);
    wc = wr_cnt;
    run_op(4'd8, 2'd0, 2'd1, n);
`ifdef ALU_CARRY_IN_EN
    checks++;
    if (n !== 6) begin $display("FAIL adc latency: got %0d want 6", n); errors++; end
    checks++;
    if ({rf[0], rf[4]} !== 16'h0003) begin $display("FAIL adc result/flags: got %h want 0003", {rf[0], rf[4]}); errors++; end
`else
    checks++;
    if (n !== 2) begin $display("FAIL op8 nop latency: got %0d want 2", n); errors++; end
    checks++;
    if (wr_cnt !== wc) begin $display("FAIL op8 writes: got %0d want 0", wr_cnt - wc); errors++; end
    checks++;
    if ({rf[0], rf[4]} !== 16'hFF01) begin $display("FAIL op8 regs kept: got %h want ff01", {rf[0], rf[4]}); errors++; end
`endif
  endtask

  task automatic test_reserved();
    int n, wc;
    wc = wr_cnt;
    run_op(4'd12, 2'd0, 2'd1, n);
    checks++;
    if (n !== 2) begin $display("FAIL reserved latency: got %0d want 2", n); errors++; end
    checks++;
    if (wr_cnt !== wc) begin $display("FAIL reserved writes: got %0d want 0", wr_cnt - wc); errors++; end
  endtask

  task automatic test_invariants();
    checks++;
    if (viol !== 0) begin $display("FAIL strobe rules: got %0d violating cycles want 0", viol); errors++; end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = '0;
    bus.dst   = '0;
    bus.src   = '0;
    test_reset();
    test_add();
    test_sub_dec();
    test_mov();
    test_xor();
    test_reset_midop();
    test_back_to_back();
    test_carry_in();
    test_reserved();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle ALU sequencer that sits in front of the 8-bit register file (registers a, b, c, d and flags f). It drives the register file's one-hot selects and read/write strobes, fetches two operands serially over the shared read bus, computes the result, and writes the result and then the updated flags back. The register file is both its operand source and its result sink; this block is the only master of the register file's control inputs.

## Interface
- W, 8, data width; fixed at 8 to match the register file.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  operation request; sampled only in IDLE.
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INC, 6 DEC, 7 MOV, 8 ADC, 9 SBC; 10–15 reserved.
- dst  in  2  destination and first operand index: 0=a, 1=b, 2=c, 3=d.
- src  in  2  second operand index, same encoding.
- p  in  W  register file read bus.
- fod  in  W  register file flags, ungated; bit0 C, bit1 Z, bit2 N, bit3 V, bits 7:4 zero.
- d  out  W  write data to the register file.
- as, bs, cs, ds, fs  out  1 each  one-hot register selects.
- re, we  out  1 each  read and write strobes.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle completion pulse.

## Operation
- States: IDLE, RDA, RDB, EXEC, WRR, WRF, NOP.
- IDLE, when start=1:
  - ops 0–4 and 8–9 go to RDA;
  - INC and DEC go to RDA;
  - MOV goes to RDB;
  - reserved ops go to NOP.
- op, dst and src are captured when start is accepted. start while busy is ignored.
- RDA: re=1, select dst; latch p into A. Next state is RDB for binary ops, EXEC for INC and DEC.
- RDB: re=1, select src; latch p into B. Next state is EXEC.
- EXEC: compute R and flags F from A, B and the latched fod; no register file strobes. Next state is WRR.
- WRR: we=1, select dst, d=R. Next state is WRF.
- WRF: we=1, fs=1, d=F. Next state is IDLE, with done=1 in that IDLE cycle.
- NOP: no strobes, no writes. Next state is IDLE with done=1.
- Register file control rules:
  - at most one select is high at any time;
  - re and we are never high together;
  - fs is never asserted with re.
- Arithmetic is modulo 2^8, computed internally with 9 bits.
  - ADD: C = carry out.
  - SUB: R = A−B; C = borrow (A<B unsigned).
  - V = signed overflow for ADD, SUB, ADC, SBC, INC, DEC.
  - AND, OR, XOR: C=0, V=0.
  - INC and DEC: C preserved from fod[0].
  - MOV: R=B; C and V preserved.
  - Z = (R==0) and N = R[7] for all non-reserved ops.
  - F[7:4] = 0.
- dst==src is legal; both reads return the same register.
- Outputs in IDLE and NOP, and after reset: d=0, all selects 0, re=0, we=0, busy=0 (NOP: busy=1), done=0 except the completion cycle.
- Reset mid-operation: the state returns to IDLE at the next edge. Any write not yet strobed is abandoned. done is not pulsed.

## Timing
- Start accepted at edge 0.
- Binary ops: RDA, RDB, EXEC, WRR, WRF occupy cycles 1–5; done is high in cycle 6. Start-to-done is 6 cycles.
- INC, DEC and MOV: 5 cycles.
- Reserved ops: 2 cycles.
- The register file read path is combinational, so p is valid within the RDA/RDB cycle and latched at its closing edge.
- The register file captures d at the closing edge of WRR and WRF.
- done and start may coincide: a start in the done cycle is accepted, giving back-to-back operations with no idle gap.

## Configuration
- ALU_CARRY_IN_EN defined:
  - ADC: R = A+B+fod[0].
  - SBC: R = A−B−fod[0].
  - Flags for both follow the ADD/SUB rules.
  - fod[0] is latched at EXEC.
- Not defined: opcodes 8 and 9 are reserved and execute as NOP. No register file access occurs and done pulses after 2 cycles.

## Test plan
- Reset, then idle 3 cycles → d=0, all selects/re/we/busy/done=0.
- a=0x7F, b=0x01; ADD dst=a src=b → a=0x80, f=0x0C (N, V); done in cycle 6 after start.
- c=0x00, d=0x01; SUB dst=c src=d → c=0xFF, f=0x05 (C, N). Then DEC dst=c with f.C=1 → c=0xFE, f=0x05 (C kept).
- MOV dst=b src=d with d=0x00 → b=0x00, Z set, C/V preserved; done after 5 cycles; no strobe ever selects b during a read.
- rst asserted in the EXEC cycle of ADD → no write to dst or f, done never pulses; next start proceeds normally.
- With ALU_CARRY_IN_EN: f.C=1, a=0xFF, b=0x00; ADC dst=a src=b → a=0x00, f=0x03. Without it, op=8 → no register change, done after 2 cycles.
